// File: rtl/data_mem_ctrl.sv
// Data memory controller for the M stage: checks load/store alignment, issues one
// bus transaction at a time, and freezes the pipeline until the response returns.
module data_mem_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_en,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  input  logic        stall_ext,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] rdata_word,
  output logic        stall,
  output logic        adel,
  output logic        ades,
  output logic [31:0] badvaddr
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, CANCEL} state_e;

  state_e      state_q, state_d;
  logic        reqWr_q, reqWr_d;
  logic [1:0]  reqSize_q, reqSize_d;
  logic [31:0] reqAddr_q;
  logic [31:0] reqWdata_q, reqWdata_d;
  logic [3:0]  reqWstrb_q, reqWstrb_d;
  logic [31:0] rdataWord_q, rdataWord_d;
  logic        start;

  always_comb begin
    adel = 1'b0;
    ades = 1'b0;
    case (mem_op)
      OP_LW:         adel = |mem_addr[1:0];
      OP_LH, OP_LHU: adel = mem_addr[0];
      OP_SW:         ades = |mem_addr[1:0];
      OP_SH:         ades = mem_addr[0];
      default:       ;
    endcase
    badvaddr = (adel || ades) ? mem_addr : 32'h0;
  end

  // Request fields as they will be latched on start; loads carry no write data.
  always_comb begin
    reqWr_d    = 1'b0;
    reqSize_d  = 2'd2;
    reqWdata_d = 32'h0;
    reqWstrb_d = 4'b0000;
    case (mem_op)
      OP_LB, OP_LBU: reqSize_d = 2'd0;
      OP_LH, OP_LHU: reqSize_d = 2'd1;
      OP_SW: begin
        reqWr_d    = 1'b1;
        reqWdata_d = mem_wdata;
        reqWstrb_d = 4'b1111;
      end
      OP_SH: begin
        reqWr_d    = 1'b1;
        reqSize_d  = 2'd1;
        reqWdata_d = {2{mem_wdata[15:0]}};
        reqWstrb_d = mem_addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_SB: begin
        reqWr_d    = 1'b1;
        reqSize_d  = 2'd0;
        reqWdata_d = {4{mem_wdata[7:0]}};
        reqWstrb_d = 4'b0001 << mem_addr[1:0];
      end
      default: ;
    endcase
  end

  assign start = (state_q == IDLE) && mem_en && !flush && !adel && !ades;

  // A flush after the address was accepted still owes us one response, so we
  // park in CANCEL to swallow it instead of mistaking it for a later load.
  always_comb begin
    state_d     = state_q;
    rdataWord_d = rdataWord_q;
    case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ: begin
        if (flush)             state_d = data_addr_ok ? CANCEL : IDLE;
        else if (data_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_d = data_data_ok ? IDLE : CANCEL;
        end else if (data_data_ok) begin
          state_d = DONE;
          if (!reqWr_q) rdataWord_d = data_rdata;
        end
      end
      DONE:    if (!stall_ext) state_d = IDLE;
      CANCEL:  if (data_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rdataWord_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rdataWord_q <= rdataWord_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reqWr_q    <= 1'b0;
      reqSize_q  <= 2'd0;
      reqAddr_q  <= 32'h0;
      reqWdata_q <= 32'h0;
      reqWstrb_q <= 4'b0000;
    end else if (start) begin
      reqWr_q    <= reqWr_d;
      reqSize_q  <= reqSize_d;
      reqAddr_q  <= mem_addr;
      reqWdata_q <= reqWdata_d;
      reqWstrb_q <= reqWstrb_d;
    end
  end

  // stall is gated by resetn so that it reads 0 while reset is held.
  assign stall = resetn && (start || (state_q == REQ) || (state_q == WAIT) ||
                            ((state_q == CANCEL) && mem_en));

  assign data_req   = (state_q == REQ);
  assign data_wr    = reqWr_q;
  assign data_size  = reqSize_q;
  assign data_addr  = reqAddr_q;
  assign data_wdata = reqWdata_q;
  assign data_wstrb = reqWstrb_q;
  assign rdata_word = rdataWord_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_data_mem_ctrl;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_en;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        flush;
  logic        stall_ext;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] rdata_word;
  logic        stall;
  logic        adel;
  logic        ades;
  logic [31:0] badvaddr;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expRdata;

  data_mem_ctrl dut (
    .clk(clk), .resetn(resetn), .mem_en(mem_en), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush), .stall_ext(stall_ext),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .rdata_word(rdata_word),
    .stall(stall), .adel(adel), .ades(ades), .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;

  // Reference rules, written from the ISA-level description of each op.
  function automatic logic isLoad(input logic [2:0] op);
    return op <= OP_LHU;
  endfunction

  function automatic logic expAdel(input logic [2:0] op, input logic [31:0] addr);
    return ((op == OP_LW) && (addr % 4 != 0)) ||
           (((op == OP_LH) || (op == OP_LHU)) && (addr % 2 != 0));
  endfunction

  function automatic logic expAdes(input logic [2:0] op, input logic [31:0] addr);
    return ((op == OP_SW) && (addr % 4 != 0)) || ((op == OP_SH) && (addr % 2 != 0));
  endfunction

  function automatic logic [1:0] expSize(input logic [2:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 2'd0;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [3:0] expWstrb(input logic [2:0] op, input logic [31:0] addr);
    if (op == OP_SW) return 4'hF;
    if (op == OP_SH) return (addr % 4 >= 2) ? 4'hC : 4'h3;
    if (op == OP_SB) return 4'(1 << (addr % 4));
    return 4'h0;
  endfunction

  function automatic logic [31:0] expWdata(input logic [2:0] op, input logic [31:0] src);
    if (op == OP_SW) return src;
    if (op == OP_SH) return 32'(src[15:0]) * 32'h0001_0001;
    if (op == OP_SB) return 32'(src[7:0]) * 32'h0101_0101;
    return 32'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] src);
    mem_en    = en;
    mem_op    = op;
    mem_addr  = addr;
    mem_wdata = src;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: aw/dw are the extra cycles before addr_ok/data_ok,
  // hold is how many extra cycles stall_ext keeps the result in DONE.
  task automatic runTxn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] src,
                        input int aw, input int dw, input logic [31:0] rd, input int hold);
    logic        err;
    int          stallCnt;
    logic [31:0] other;
    applyStimulus(1'b1, op, addr, src);
    flush = 1'b0; stall_ext = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    err = expAdel(op, addr) || expAdes(op, addr);
    checkBit("adel", adel, expAdel(op, addr));
    checkBit("ades", ades, expAdes(op, addr));
    checkOutput("badvaddr", badvaddr, err ? addr : 32'h0);
    if (err) begin
      checkBit("errStall", stall, 1'b0);
      checkBit("errReq", data_req, 1'b0);
      tick();
      checkBit("errReqNext", data_req, 1'b0);
      applyStimulus(1'b0, op, addr, src);
      #1;
      return;
    end
    checkBit("startStall", stall, 1'b1);
    checkBit("idleReq", data_req, 1'b0);
    stallCnt = int'(stall);
    tick();
    for (int i = 0; i <= aw; i++) begin
      data_addr_ok = (i == aw);
      data_data_ok = 1'($urandom % 2);
      data_rdata   = $urandom;
      #1;
      checkBit("reqReq", data_req, 1'b1);
      checkBit("reqWr", data_wr, !isLoad(op));
      checkOutput("reqSize", 32'(data_size), 32'(expSize(op)));
      checkOutput("reqAddr", data_addr, addr);
      checkOutput("reqWdata", data_wdata, expWdata(op, src));
      checkOutput("reqWstrb", 32'(data_wstrb), 32'(expWstrb(op, addr)));
      stallCnt += int'(stall);
      tick();
    end
    for (int j = 0; j <= dw; j++) begin
      data_addr_ok = 1'($urandom % 2);
      data_data_ok = (j == dw);
      data_rdata   = (j == dw) ? rd : $urandom;
      #1;
      checkBit("waitReq", data_req, 1'b0);
      stallCnt += int'(stall);
      tick();
    end
    if (isLoad(op)) expRdata = rd;
    applyStimulus(1'b0, op, addr, src);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = $urandom;
    stall_ext = (hold > 0);
    #1;
    checkBit("doneStall", stall, 1'b0);
    checkBit("doneReq", data_req, 1'b0);
    checkOutput("doneRdata", rdata_word, expRdata);
    checkOutput("stallCycles", 32'(stallCnt), 32'(3 + aw + dw));
    for (int h = 0; h < hold; h++) begin
      tick();
      other = $urandom & 32'hFFFF_FFFC;
      applyStimulus(1'b1, OP_LW, other, 32'h0);
      data_data_ok = 1'b0;
      stall_ext = (h < hold - 1);
      #1;
      checkBit("holdStall", stall, 1'b0);
      checkBit("holdReq", data_req, 1'b0);
      checkOutput("holdRdata", rdata_word, expRdata);
    end
    tick();
    applyStimulus(1'b0, op, addr, src);
    data_data_ok = 1'b0; stall_ext = 1'b0;
    #1;
    checkBit("idleStall", stall, 1'b0);
    checkBit("idleReqAfter", data_req, 1'b0);
    checkOutput("idleRdata", rdata_word, expRdata);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] addr;
    expRdata = 32'h0;
    resetn = 1'b0; flush = 1'b0; stall_ext = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    applyStimulus(1'b1, OP_LW, 32'h0000_0010, 32'h0);
    #12;
    checkBit("rstStall", stall, 1'b0);
    checkBit("rstReq", data_req, 1'b0);
    checkOutput("rstAddr", data_addr, 32'h0);
    checkOutput("rstRdata", rdata_word, 32'h0);
    applyStimulus(1'b1, OP_LH, 32'h0000_0101, 32'h0);
    #1;
    checkBit("rstAdel", adel, 1'b1);
    checkOutput("rstBadv", badvaddr, 32'h0000_0101);
    applyStimulus(1'b0, OP_LW, 32'h0, 32'h0);
    #10 resetn = 1'b1;
    tick();

    runTxn(OP_LW, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
    runTxn(OP_SB, 32'h0000_0103, 32'h0000_00A5, 1, 1, 32'h1111_2222, 1);
    runTxn(OP_LH, 32'h0000_0101, 32'h0, 0, 0, 32'h0, 0);
    runTxn(OP_SH, 32'h0000_0202, 32'h1234_ABCD, 4, 0, 32'h3333_4444, 0);
    runTxn(OP_SW, 32'h0000_0206, 32'h5555_6666, 0, 0, 32'h0, 0);

    // Flushed op in IDLE never starts.
    applyStimulus(1'b1, OP_LW, 32'h0000_0040, 32'h0);
    flush = 1'b1;
    #1;
    checkBit("flushIdleStall", stall, 1'b0);
    tick();
    checkBit("flushIdleReq", data_req, 1'b0);
    flush = 1'b0; mem_en = 1'b0;

    // Flush in REQ before acceptance drops the request; late data_ok ignored.
    applyStimulus(1'b1, OP_LW, 32'h0000_0044, 32'h0);
    tick();
    flush = 1'b1;
    #1;
    checkBit("flReqReq", data_req, 1'b1);
    tick();
    flush = 1'b0; mem_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hBAD0_0001;
    #1;
    checkBit("flReqIdleReq", data_req, 1'b0);
    checkBit("flReqIdleStall", stall, 1'b0);
    tick();
    data_data_ok = 1'b0;
    applyStimulus(1'b1, OP_LH, 32'h0000_0033, 32'h0);
    #1;
    checkBit("flReqNotCancel", stall, 1'b0);
    checkOutput("flReqRdata", rdata_word, expRdata);
    mem_en = 1'b0;

    // Flush in REQ with acceptance goes to CANCEL.
    applyStimulus(1'b1, OP_LW, 32'h0000_0048, 32'h0);
    tick();
    data_addr_ok = 1'b1; flush = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush = 1'b0;
    applyStimulus(1'b1, OP_LH, 32'h0000_0031, 32'h0);
    #1;
    checkBit("cancelStall", stall, 1'b1);
    checkBit("cancelAdel", adel, 1'b1);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'hBAD0_0002;
    #1;
    checkBit("cancelStall2", stall, 1'b1);
    tick();
    data_data_ok = 1'b0;
    #1;
    checkBit("cancelToIdle", stall, 1'b0);
    checkOutput("cancelRdata", rdata_word, expRdata);
    mem_en = 1'b0;

    // Flush in WAIT, response two cycles later is discarded.
    applyStimulus(1'b1, OP_LW, 32'h0000_0080, 32'h0);
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush = 1'b1;
    #1;
    checkBit("flWaitStall", stall, 1'b1);
    tick();
    flush = 1'b0;
    applyStimulus(1'b1, OP_LH, 32'h0000_0033, 32'h0);
    #1;
    checkBit("flWaitCancel", stall, 1'b1);
    checkBit("flWaitReq", data_req, 1'b0);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'hBAD0_0003;
    tick();
    data_data_ok = 1'b0;
    #1;
    checkBit("flWaitIdle", stall, 1'b0);
    checkOutput("flWaitRdata", rdata_word, expRdata);
    mem_en = 1'b0;

    // Flush and data_ok together in WAIT return straight to IDLE.
    applyStimulus(1'b1, OP_LW, 32'h0000_0084, 32'h0);
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hBAD0_0004;
    tick();
    flush = 1'b0; data_data_ok = 1'b0;
    applyStimulus(1'b1, OP_LH, 32'h0000_0033, 32'h0);
    #1;
    checkBit("flOkIdle", stall, 1'b0);
    checkOutput("flOkRdata", rdata_word, expRdata);
    mem_en = 1'b0;

    // Asynchronous reset in WAIT.
    applyStimulus(1'b1, OP_LW, 32'h0000_0090, 32'h0);
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    #2 resetn = 1'b0;
    expRdata = 32'h0;
    #1;
    checkBit("rstWaitReq", data_req, 1'b0);
    checkBit("rstWaitStall", stall, 1'b0);
    checkOutput("rstWaitRdata", rdata_word, 32'h0);
    tick();
    #1 resetn = 1'b1;
    mem_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hBAD0_0005;
    tick();
    data_data_ok = 1'b0;
    applyStimulus(1'b1, OP_LH, 32'h0000_0033, 32'h0);
    #1;
    checkBit("postRstStall", stall, 1'b0);
    checkOutput("postRstRdata", rdata_word, 32'h0);
    mem_en = 1'b0;
    tick();

    for (int n = 0; n < 40; n++) begin
      op   = 3'($urandom % 8);
      addr = $urandom;
      if ($urandom % 2 == 0) addr = addr & 32'hFFFF_FFFC;
      runTxn(op, addr, $urandom, int'($urandom % 3), int'($urandom % 3), $urandom,
             int'($urandom % 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
